ysyx_22050598_if_fetch: RTL and testbench
=========================================

// Module: ysyx_22050598_if_fetch
// PURPOSE
//  Instruction-fetch producer feeding the IF/ID pipeline register: owns the PC, issues 32-bit
//  fetches to instruction memory over a valid/ready request + valid response handshake, and
//  presents {if_pc_o, if_inst_o, if_bubble_o}. Top level ORs if_bubble_o into the IF/ID flush.
//  Honours the hazard-unit stall and EX-stage redirects (branch/jump), dropping wrong-path data.
// PARAMETERS
//  RESET_PC   64'h0000_0000_8000_0000   PC after reset
//  NOP_INST   32'h0000_0013             instruction driven while bubbling (addi x0,x0,0)
// PORTS
//  clk              in   1   clock; all state updates on posedge
//  rst              in   1   synchronous, active-high reset
//  if_stall         in   1   downstream not accepting; hold presented instruction
//  redirect_valid   in   1   EX redirect this cycle; highest priority
//  redirect_pc      in   64  redirect target; bits [1:0] forced to 00
//  imem_req_valid   out  1   fetch request valid
//  imem_req_ready   in   1   memory accepts request (handshake = valid & ready)
//  imem_req_addr    out  64  fetch address (= pc_r)
//  imem_rsp_valid   in   1   response valid, exactly one per accepted request, >=1 cycle later
//  imem_rsp_data    in   32  fetched instruction
//  if_pc_o          out  64  PC of presented instruction (0 when bubbling)
//  if_inst_o        out  32  presented instruction (NOP_INST when bubbling)
//  if_bubble_o      out  1   1 = no valid instruction this cycle
// BEHAVIOUR
//  - Reset: pc_r=RESET_PC, state=S_REQ, buffer cleared; outputs bubble=1, inst=NOP_INST, pc=0.
//  - At most one outstanding request. States:
//    S_REQ : req_valid=1, bubble=1. Handshake -> S_WAIT.
//    S_WAIT: req_valid=0. rsp_valid: present rsp data + pc_r combinationally (bubble=0);
//            stall=0 -> pc_r+=4, S_REQ (consumed); stall=1 -> capture into buffer, S_HOLD.
//            No rsp: bubble=1, stay.
//    S_HOLD: present buffer + pc_r, bubble=0; stall=0 -> pc_r+=4, S_REQ; else stay.
//    S_DROP: req_valid=0, bubble=1; rsp_valid -> data discarded, S_REQ.
//  - Consumption = bubble=0 & stall=0 in same cycle; pc_r advances exactly once per consumption.
//  - Redirect (any state, overrides stall and all above): pc_r<=redirect_pc&~3, bubble forced 1,
//    buffer discarded. Next state: S_DROP if a request is outstanding after this cycle
//    (S_WAIT without rsp, or S_REQ with handshake this cycle); otherwise S_REQ.
//  - Stall does not block S_REQ/S_WAIT progress (one-deep prefetch); only consumption waits.
//  - PC arithmetic 64-bit, wraps modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC + 4 -> 0).
//  - rst overrides redirect; reset mid-transaction abandons it: the system resets imem in the
//    same cycle, so no stale response is expected and none is tracked.
//  - Latency: redirect -> first redirect-target request >= 1 cycle; zero-wait memory gives one
//    instruction per 2 cycles (REQ, WAIT).
// STRUCTURE
//  - Defines file: state encodings S_REQ/S_WAIT/S_HOLD/S_DROP (2-bit), NOP_INST, RESET_PC macros.
//  - pc_r, state, and 32-bit hold buffer built from ysyx_22050598_sirv_gnrl_dfflr; next-state/
//    output logic combinational in this module. No new sub-module.
// TESTING
//  1 Reset, ready=1, rsp 1 cycle later = 0x00100093, stall=0 -> req_addr 0x80000000; next cycle
//    if_inst_o=0x00100093, pc_o=0x80000000, bubble=0; following request addr 0x80000004.
//  2 Response arrives with stall=1 for 3 cycles -> inst/pc held stable 3 cycles, bubble=0;
//    pc_r stays 0x80000000 until stall drops; then request 0x80000004 issued once.
//  3 Redirect to 0x80001002 while S_WAIT, rsp next cycle = 0xDEADBEEF -> data dropped (bubble=1),
//    next request addr 0x80001000.
//  4 Redirect same cycle as rsp_valid -> rsp discarded, bubble=1, next state S_REQ, no S_DROP.
//  5 req_ready held 0 for 5 cycles -> req_valid stays 1, req_addr stable, bubble=1 throughout.
//  6 Redirect to 0xFFFF_FFFF_FFFF_FFFC, consume one -> next fetch addr 0x0; rst mid-S_WAIT ->
//    next cycle req_valid=1 at 0x80000000, bubble=1.

Source files
------------

// File: rtl/ysyx_22050598_if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : 2-bit fetch FSM encoding
//   RESET_PC_DEF  : default PC after reset
//   NOP_INST_DEF  : default instruction presented while bubbling (addi x0,x0,0)
//   align_pc()    : clears the two low address bits of a redirect target
package ysyx_22050598_if_fetch_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,  // request being offered to imem
        S_WAIT = 2'd1,  // request accepted, waiting for the response
        S_HOLD = 2'd2,  // response captured, waiting for downstream to take it
        S_DROP = 2'd3   // wrong-path response still in flight, discard it
    } fetch_state_e;

    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    function automatic logic [63:0] align_pc(input logic [63:0] pc);
        return {pc[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_22050598_sirv_gnrl_dfflr.sv
// Generic load-enabled register with synchronous active-high reset.
//   clk  : clock
//   rst  : synchronous reset, loads RST_VAL
//   lden : load enable
//   dnxt : next value
//   qout : registered value
module ysyx_22050598_sirv_gnrl_dfflr #(
    parameter int              DW      = 32,
    parameter logic [DW-1:0]   RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    always_ff @(posedge clk) begin
        if (rst)       qout <= RST_VAL;
        else if (lden) qout <= dnxt;
    end

endmodule

// File: rtl/ysyx_22050598_if_fetch.sv
// Instruction-fetch producer feeding the IF/ID register.
// Owns the PC, keeps at most one imem request in flight, and presents one
// instruction at a time with a bubble flag. EX redirects override everything
// and any wrong-path response still in flight is dropped.
//   clk, rst        : clock, synchronous active-high reset
//   if_stall        : downstream is not taking the presented instruction
//   redirect_valid  : EX redirect this cycle, target in redirect_pc
//   imem_req_*      : fetch request (valid/ready), address = pc_r
//   imem_rsp_*      : fetch response, one per accepted request
//   if_pc_o/if_inst_o/if_bubble_o : presented instruction (0 / NOP when bubbling)
module ysyx_22050598_if_fetch
    import ysyx_22050598_if_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [63:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_bubble_o
);

    logic [63:0]  pc_r, pc_nxt;
    logic [1:0]   state_raw;
    fetch_state_e state, state_nxt;
    logic [31:0]  hold_buf;
    logic         buf_ld;
    logic         req_hs;
    logic         in_flight;

    ysyx_22050598_sirv_gnrl_dfflr #(.DW(64), .RST_VAL(RESET_PC)) u_pc (
        .clk(clk), .rst(rst), .lden(1'b1), .dnxt(pc_nxt), .qout(pc_r)
    );

    ysyx_22050598_sirv_gnrl_dfflr #(.DW(2), .RST_VAL(2'(S_REQ))) u_state (
        .clk(clk), .rst(rst), .lden(1'b1), .dnxt(2'(state_nxt)), .qout(state_raw)
    );

    ysyx_22050598_sirv_gnrl_dfflr #(.DW(32), .RST_VAL(32'd0)) u_buf (
        .clk(clk), .rst(rst), .lden(buf_ld), .dnxt(imem_rsp_data), .qout(hold_buf)
    );

    assign state          = fetch_state_e'(state_raw);
    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc_r;
    assign req_hs         = imem_req_valid & imem_req_ready;

    // A request is still owed a response after this cycle if it was just
    // accepted, or was accepted earlier and its response has not shown up yet.
    assign in_flight = ((state == S_REQ) & req_hs) |
                       (((state == S_WAIT) | (state == S_DROP)) & ~imem_rsp_valid);

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc_r;
        buf_ld      = 1'b0;
        if_bubble_o = 1'b1;
        if_pc_o     = 64'd0;
        if_inst_o   = NOP_INST;

        case (state)
            S_REQ: begin
                if (req_hs) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Response is forwarded in the cycle it arrives; it is only
                // buffered if downstream cannot take it right away.
                if (imem_rsp_valid) begin
                    if_bubble_o = 1'b0;
                    if_pc_o     = pc_r;
                    if_inst_o   = imem_rsp_data;
                    if (if_stall) begin
                        buf_ld    = 1'b1;
                        state_nxt = S_HOLD;
                    end else begin
                        pc_nxt    = pc_r + 64'd4;
                        state_nxt = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if_bubble_o = 1'b0;
                if_pc_o     = pc_r;
                if_inst_o   = hold_buf;
                if (!if_stall) begin
                    pc_nxt    = pc_r + 64'd4;
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rsp_valid) state_nxt = S_REQ;
            end
            default: state_nxt = S_REQ;
        endcase

        // Redirect wins over stall and over whatever the state wanted; the
        // held instruction is abandoned simply by leaving S_HOLD.
        if (redirect_valid) begin
            if_bubble_o = 1'b1;
            if_pc_o     = 64'd0;
            if_inst_o   = NOP_INST;
            buf_ld      = 1'b0;
            pc_nxt      = align_pc(redirect_pc);
            state_nxt   = in_flight ? S_DROP : S_REQ;
        end
    end

endmodule

// File: tb/tb_ysyx_22050598_if_fetch.sv
// Randomized scoreboard bench for the fetch stage. A driver plays the role of
// imem, the hazard unit and EX; a monitor keeps a program-order model (next
// architectural PC, redirect epoch, queue of correct-path instructions) and
// compares on every cycle the DUT presents or requests something.
module tb_ysyx_22050598_if_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic [63:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_bubble_o;

    ysyx_22050598_if_fetch dut (
        .clk(clk), .rst(rst), .if_stall(if_stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .if_pc_o(if_pc_o), .if_inst_o(if_inst_o), .if_bubble_o(if_bubble_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        q[$];
    logic [63:0] mpc = RST_PC;
    logic [63:0] req_addr_m = 64'd0;
    int          epoch = 0;
    int          req_epoch = -1;
    bit          outst = 1'b0;
    bit          post_rst = 1'b0;
    bit          prev_reqv = 1'b0;
    bit          prev_hs = 1'b0;
    bit          prev_redir = 1'b0;
    logic [63:0] prev_addr = 64'd0;
    int          idle = 0;
    int          consumed = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mpc = RST_PC; q.delete(); outst = 1'b0; epoch++;
                post_rst = 1'b1; prev_reqv = 1'b0; idle = 0;
            end else begin
                automatic bit hs = imem_req_valid & imem_req_ready;
                if (post_rst) begin
                    chk("rst_req_valid", 64'(imem_req_valid), 64'd1);
                    chk("rst_req_addr", imem_req_addr, RST_PC);
                    chk("rst_bubble", 64'(if_bubble_o), 64'd1);
                    post_rst = 1'b0;
                end
                // An unaccepted request must be held steady
                if (prev_reqv && !prev_hs && !prev_redir) begin
                    chk("req_hold_valid", 64'(imem_req_valid), 64'd1);
                    chk("req_hold_addr", imem_req_addr, prev_addr);
                end
                if (if_bubble_o) begin
                    chk("bubble_pc", if_pc_o, 64'd0);
                    chk("bubble_inst", 64'(if_inst_o), 64'(NOP));
                end
                if (redirect_valid) begin
                    chk("redir_bubble", 64'(if_bubble_o), 64'd1);
                    if (hs) begin
                        chk("one_outstanding", 64'(outst), 64'd0);
                        chk("req_addr", imem_req_addr, mpc);
                        outst = 1'b1; req_epoch = epoch;
                    end else if (imem_rsp_valid) begin
                        outst = 1'b0;
                    end
                    epoch++;
                    q.delete();
                    mpc = redirect_pc & ~64'd3;
                end else begin
                    if (hs) begin
                        chk("one_outstanding", 64'(outst), 64'd0);
                        chk("req_addr", imem_req_addr, mpc);
                        outst = 1'b1; req_epoch = epoch; req_addr_m = imem_req_addr;
                    end
                    if (imem_rsp_valid) begin
                        outst = 1'b0;
                        if (req_epoch == epoch) q.push_back('{req_addr_m, imem_rsp_data});
                    end
                    chk("presenting", 64'(!if_bubble_o), 64'(q.size() != 0));
                    if (!if_bubble_o && q.size() != 0) begin
                        chk("pres_pc", if_pc_o, q[0].pc);
                        chk("pres_inst", 64'(if_inst_o), 64'(q[0].inst));
                        if (!if_stall) begin
                            chk("consume_pc", if_pc_o, mpc);
                            mpc = mpc + 64'd4;
                            void'(q.pop_front());
                            idle = 0;
                            consumed++;
                        end
                    end
                end
                idle++;
                if (idle > 200) begin
                    checks++; errors++;
                    $display("FAIL liveness got=%0d idle cycles exp<=200 @%0t", idle, $time);
                    idle = 0;
                end
                prev_reqv  = imem_req_valid;
                prev_hs    = hs;
                prev_redir = redirect_valid;
                prev_addr  = imem_req_addr;
            end
        end
    end

    // ---------------- driver: imem, hazard unit, EX ----------------
    initial begin
        automatic bit pend = 1'b0;
        automatic int dly = 0;
        automatic int low_cnt = 0;
        automatic int n_redir = 0;
        logic [63:0] targets [4];
        targets[0] = 64'h0000_0000_8000_1002;
        targets[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        targets[2] = 64'h0000_0000_8000_0100;
        targets[3] = 64'h0000_0000_8000_0000;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (!rst && imem_req_valid && imem_req_ready) begin
                pend = 1'b1;
                dly  = int'($urandom_range(0, 2));
            end
            @(posedge clk);
            #1;
            rst = ($urandom_range(0, 199) == 0);
            imem_rsp_data = $urandom;
            if (rst) begin
                pend = 1'b0;
                imem_rsp_valid = 1'b0;
            end else if (pend && dly == 0) begin
                imem_rsp_valid = 1'b1;
                pend = 1'b0;
            end else begin
                imem_rsp_valid = 1'b0;
                if (pend) dly--;
            end
            if_stall = ($urandom_range(0, 9) < 3);
            if (low_cnt > 0) begin
                imem_req_ready = 1'b0;
                low_cnt--;
            end else if ($urandom_range(0, 39) == 0) begin
                imem_req_ready = 1'b0;
                low_cnt = 4;
            end else begin
                imem_req_ready = ($urandom_range(0, 3) != 0);
            end
            redirect_valid = ($urandom_range(0, 24) == 0);
            if (redirect_valid) begin
                n_redir++;
                if (n_redir % 2 == 0) redirect_pc = targets[$urandom_range(0, 3)];
                else redirect_pc = {32'h0000_0000, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
            end
        end

        @(posedge clk);
        #1;
        rst = 1'b0; redirect_valid = 1'b0;
        if (consumed < 100) begin
            checks++; errors++;
            $display("FAIL throughput got=%0d consumed exp>=100", consumed);
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
